// File: rtl/mont_r2_precompute.sv
`default_nettype none
// ============================================================================
// Module   : mont_r2_precompute
// Purpose  : Sequential computation of R2 = 2^(2*BITS) mod M by repeated
//            modular doubling, for the Montgomery exponentiation datapath.
//            Optional macro MONT_R2_ODD_CHECK_EN rejects even moduli.
// Revision : 1.0  initial release
// ============================================================================
module mont_r2_precompute #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            go,
    input  logic [BITS-1:0] M,
    output logic            done,
    output logic            busy,
    output logic [BITS-1:0] R2,
    output logic [BITS-1:0] Mo,
    output logic            err
);

    localparam int            CW     = (BITS > 1) ? $clog2(2 * BITS) : 1;
    localparam logic [CW-1:0] c_last = CW'(2 * BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [BITS-1:0] r_r;
    logic [BITS-1:0] r_mo;
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    logic            w_reject;
    logic [BITS:0]   w_two_r;
    logic            w_ge;
    logic [BITS-1:0] w_r_next;

`ifdef MONT_R2_ODD_CHECK_EN
    assign w_reject = (M == '0) || !M[0];
`else
    assign w_reject = (M == '0);
`endif

    // r < Mo always holds, so the reduced value fits back into BITS bits and
    // the subtraction may be done modulo 2^BITS.
    assign w_two_r  = {r_r, 1'b0};
    assign w_ge     = (w_two_r >= {1'b0, r_mo});
    assign w_r_next = w_ge ? (w_two_r[BITS-1:0] - r_mo) : w_two_r[BITS-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_state_next = w_reject ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == c_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!go) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_r   <= '0;
            r_mo  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_mo  <= M;
                        r_cnt <= '0;
                        r_err <= w_reject;
                        r_r   <= (w_reject || (M == BITS'(1))) ? '0 : BITS'(1);
                    end
                end
                S_RUN: begin
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign done = (r_state == S_DONE);
    assign busy = (r_state == S_RUN);
    assign R2   = r_r;
    assign Mo   = r_mo;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mont_r2_precompute.sv
`default_nettype none
// ============================================================================
// Module   : tb_mont_r2_precompute
// Purpose  : Scoreboard bench for mont_r2_precompute (BITS=4) with directed
//            moduli and hand-computed R2 values.
// Revision : 1.0  initial release
// ============================================================================
module tb_mont_r2_precompute;

    localparam int BITS = 4;

    typedef struct {
        logic [BITS-1:0] r2;
        logic [BITS-1:0] mo;
        logic            err;
        int              cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            go = 1'b0;
    logic [BITS-1:0] M = '0;
    logic            done;
    logic            busy;
    logic [BITS-1:0] R2;
    logic [BITS-1:0] Mo;
    logic            err;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic done_q = 1'b0;
    exp_t exp_q[$];

    mont_r2_precompute #(.BITS(BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .M     (M),
        .done  (done),
        .busy  (busy),
        .R2    (R2),
        .Mo    (Mo),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every rising edge of done is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("r2",      32'(R2),  32'(e.r2));
                check("mo",      32'(Mo),  32'(e.mo));
                check("err",     32'(err), 32'(e.err));
                check("latency", 32'(cyc), 32'(e.cyc));
            end
        end
        done_q = done;
    end

    task automatic start(input logic [BITS-1:0] m, input logic [BITS-1:0] r2,
                         input logic e, input int lat);
        exp_t x;
        @(negedge clk);
        M  = m;
        go = 1'b1;
        @(posedge clk);
        #1;
        x.r2 = r2; x.mo = m; x.err = e; x.cyc = cyc + lat;
        exp_q.push_back(x);
    endtask

    task automatic wait_done(input int lat);
        int  nbusy;
        bit  seen;
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_cycles", 32'(nbusy), 32'(lat));
    endtask

    task automatic finish_op(input logic [BITS-1:0] r2);
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);
        #1;
        check("done_drop", 32'(done), 32'd0);
        check("r2_hold_idle", 32'(R2), 32'(r2));
    endtask

    task automatic run_op(input logic [BITS-1:0] m, input logic [BITS-1:0] r2,
                          input logic e, input int lat);
        start(m, r2, e, lat);
        wait_done(lat);
        finish_op(r2);
    endtask

    initial begin
        reset = 1'b1;
        #12;
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_r2",   32'(R2),   32'd0);
        check("rst_mo",   32'(Mo),   32'd0);
        @(negedge clk);
        reset = 1'b0;

`ifdef MONT_R2_ODD_CHECK_EN
        run_op(4'd6, 4'd0, 1'b1, 0);
`else
        run_op(4'd6, 4'd4, 1'b0, 8);
`endif
        run_op(4'd13, 4'd9, 1'b0, 8);
        run_op(4'd15, 4'd1, 1'b0, 8);
        run_op(4'd1,  4'd0, 1'b0, 8);
        run_op(4'd0,  4'd0, 1'b1, 0);

        // M and go change mid-run; result uses the captured modulus
        start(4'd13, 4'd9, 1'b0, 8);
        repeat (3) @(negedge clk);
        M  = 4'd7;
        go = 1'b0;
        wait_done(5);
        @(posedge clk);
        #1;
        check("done_one_edge", 32'(done), 32'd0);

        // Asynchronous abort mid-run
        @(negedge clk);
        M  = 4'd13;
        go = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_r2",   32'(R2),   32'd0);
        check("abort_mo",   32'(Mo),   32'd0);
        go = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_op(4'd11, 4'd3, 1'b0, 8);

        // go held through DONE must not restart
        start(4'd5, 4'd1, 1'b0, 8);
        wait_done(8);
        repeat (3) begin
            @(negedge clk);
            check("hold_done", 32'(done), 32'd1);
            check("hold_busy", 32'(busy), 32'd0);
        end
        go = 1'b0;
        run_op(4'd9, 4'd4, 1'b0, 8);

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
